// File: rtl/stack_pkg.sv
// Shared op-code encodings and error-cause constants for stack_unit and its RAM.
package stack_pkg;

    typedef enum logic [2:0] {
        NOP     = 3'b000,
        PUSH    = 3'b001,
        POP     = 3'b010,
        REPLACE = 3'b011,
        BINOP   = 3'b100,
        DUP     = 3'b101,
        CLEAR   = 3'b110,
        RSVD    = 3'b111
    } stack_op_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;

endpackage

// File: rtl/stack_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, two asynchronous read ports.
module stack_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr0,
    input  logic [AW-1:0]    i_raddr1,
    output logic [WIDTH-1:0] o_rdata0,
    output logic [WIDTH-1:0] o_rdata1
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/stack_unit.sv
// Parametrised hardware stack with combinational TOS/NOS fetch.
// Define STACK_GUARD_EN to suppress illegal ops and record a sticky error cause.
module stack_unit
    import stack_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 op,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           tos,
    output logic [WIDTH-1:0]           nos,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       err,
    output logic [1:0]                 err_code
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_ZERO  = '0;
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW-1:0] C_TWO   = CW'(2);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_next;
    stack_op_e        w_op;
    logic             w_we;
    logic             w_ok;
    logic [AW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic [AW-1:0]    w_raddr0;
    logic [AW-1:0]    w_raddr1;
    logic [WIDTH-1:0] w_rd0;
    logic [WIDTH-1:0] w_rd1;

    assign w_op     = stack_op_e'(op);
    assign w_raddr0 = AW'(r_count - C_ONE);
    assign w_raddr1 = AW'(r_count - C_TWO);

    // Entries below count are the only valid ones; mask stale RAM contents.
    assign tos   = (r_count == C_ZERO) ? '0 : w_rd0;
    assign nos   = (r_count <  C_TWO)  ? '0 : w_rd1;
    assign count = r_count;
    assign empty = (r_count == C_ZERO);
    assign full  = (r_count == C_DEPTH);

    always_comb begin
        w_we         = 1'b0;
        w_waddr      = r_count[AW-1:0];
        w_wdata      = wdata;
        w_count_next = r_count;
        case (w_op)
            PUSH: begin
                w_we         = 1'b1;
                w_count_next = r_count + C_ONE;
            end
            POP: begin
                w_count_next = r_count - C_ONE;
            end
            REPLACE: begin
                w_we    = 1'b1;
                w_waddr = w_raddr0;
            end
            BINOP: begin
                w_we         = 1'b1;
                w_waddr      = w_raddr1;
                w_count_next = r_count - C_ONE;
            end
            DUP: begin
                w_we         = 1'b1;
                w_wdata      = tos;
                w_count_next = r_count + C_ONE;
            end
            CLEAR: begin
                w_count_next = C_ZERO;
            end
            default: begin
            end
        endcase
    end

`ifdef STACK_GUARD_EN
    logic       w_illegal;
    logic [1:0] w_cause;
    logic       r_err;
    logic [1:0] r_err_code;

    always_comb begin
        w_illegal = 1'b0;
        w_cause   = ERR_NONE;
        case (w_op)
            PUSH: begin
                if (r_count == C_DEPTH) begin
                    w_illegal = 1'b1;
                    w_cause   = ERR_OVF;
                end
            end
            POP, REPLACE: begin
                if (r_count == C_ZERO) begin
                    w_illegal = 1'b1;
                    w_cause   = ERR_UNF;
                end
            end
            BINOP: begin
                if (r_count < C_TWO) begin
                    w_illegal = 1'b1;
                    w_cause   = ERR_UNF;
                end
            end
            DUP: begin
                if (r_count == C_ZERO) begin
                    w_illegal = 1'b1;
                    w_cause   = ERR_UNF;
                end else if (r_count == C_DEPTH) begin
                    w_illegal = 1'b1;
                    w_cause   = ERR_OVF;
                end
            end
            default: begin
            end
        endcase
    end

    assign w_ok = ~w_illegal;

    // First cause sticks until CLEAR or reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else if (w_op == CLEAR) begin
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else if (w_illegal) begin
            r_err <= 1'b1;
            if (r_err_code == ERR_NONE) begin
                r_err_code <= w_cause;
            end
        end
    end

    assign err      = r_err;
    assign err_code = r_err_code;
`else
    assign w_ok     = 1'b1;
    assign err      = 1'b0;
    assign err_code = ERR_NONE;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= C_ZERO;
        end else if (w_ok) begin
            r_count <= w_count_next;
        end
    end

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk      (clk),
        .i_we     (w_we & w_ok),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata),
        .i_raddr0 (w_raddr0),
        .i_raddr1 (w_raddr1),
        .o_rdata0 (w_rd0),
        .o_rdata1 (w_rd1)
    );

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit at DEPTH=4; guarded or wrapping checks chosen by STACK_GUARD_EN.
module tb_stack_unit;
    import stack_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset;
    logic [2:0]       op;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             err;
    logic [1:0]       err_code;

    int total;
    int bad;

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .wdata    (wdata),
        .tos      (tos),
        .nos      (nos),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .err      (err),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [WIDTH-1:0] d);
        @(negedge clk);
        op    = o;
        wdata = d;
        @(posedge clk);
        #1;
        op    = NOP;
        $display("op=%0d wdata=%0h -> count=%0d tos=%0h nos=%0h err=%0b code=%0b",
                 o, d, count, tos, nos, err, err_code);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        op    = NOP;
        wdata = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_tos",   tos, 0);
        chk("rst_nos",   nos, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full",  full, 0);
        chk("rst_err",   err, 0);
        chk("rst_code",  err_code, 0);

        do_op(PUSH, 16'd7);
        do_op(PUSH, 16'd4);
        do_op(PUSH, 16'd3);
        chk("push3_count", count, 3);
        chk("push3_tos",   tos, 3);
        chk("push3_nos",   nos, 4);

        do_op(BINOP, 16'd12);
        chk("binop_count", count, 2);
        chk("binop_tos",   tos, 12);
        chk("binop_nos",   nos, 7);

        do_op(DUP, 16'd0);
        chk("dup_count", count, 3);
        chk("dup_tos",   tos, 12);
        chk("dup_nos",   nos, 12);

        do_op(REPLACE, 16'd5);
        chk("repl_count", count, 3);
        chk("repl_tos",   tos, 5);
        chk("repl_nos",   nos, 12);

        do_op(PUSH, 16'd1);
        chk("full_count", count, 4);
        chk("full_flag",  full, 1);
        chk("full_tos",   tos, 1);
        chk("full_nos",   nos, 5);

`ifdef STACK_GUARD_EN
        do_op(PUSH, 16'd9);
        chk("ovf_count", count, 4);
        chk("ovf_tos",   tos, 1);
        chk("ovf_nos",   nos, 5);
        chk("ovf_err",   err, 1);
        chk("ovf_code",  err_code, ERR_OVF);
        for (int i = 0; i < 5; i++) begin
            do_op(POP, 16'd0);
        end
        chk("pop5_count", count, 0);
        chk("pop5_empty", empty, 1);
        chk("pop5_err",   err, 1);
        chk("pop5_code",  err_code, ERR_OVF);

        do_op(CLEAR, 16'd0);
        chk("clr_count", count, 0);
        chk("clr_empty", empty, 1);
        chk("clr_err",   err, 0);
        chk("clr_code",  err_code, ERR_NONE);

        do_op(POP, 16'd0);
        chk("unf_err",   err, 1);
        chk("unf_code",  err_code, ERR_UNF);
        chk("unf_count", count, 0);
        chk("unf_tos",   tos, 0);

        do_op(PUSH, 16'd8);
        do_op(BINOP, 16'd3);
        chk("binop1_count", count, 1);
        chk("binop1_tos",   tos, 8);
        chk("binop1_code",  err_code, ERR_UNF);

        do_op(DUP, 16'd0);
        chk("dup1_count", count, 2);
        chk("dup1_nos",   nos, 8);

        do_op(CLEAR, 16'd0);
        chk("clr2_err", err, 0);
`else
        do_op(PUSH, 16'd9);
        chk("wrap_push_count", count, 5);
        chk("wrap_push_tos",   tos, 9);
        chk("wrap_push_nos",   nos, 1);
        chk("wrap_push_full",  full, 0);
        chk("wrap_push_err",   err, 0);

        do_op(CLEAR, 16'd0);
        chk("clr_count", count, 0);
        chk("clr_empty", empty, 1);

        do_op(POP, 16'd0);
        chk("wrap_pop_count", count, 7);
        chk("wrap_pop_err",   err, 0);
        chk("wrap_pop_code",  err_code, 0);
        chk("wrap_pop_empty", empty, 0);
        chk("wrap_pop_tos",   tos, 5);

        do_op(PUSH, 16'h55);
        chk("wrap0_count", count, 0);
        chk("wrap0_tos",   tos, 0);
        chk("wrap0_nos",   nos, 0);
        chk("wrap0_empty", empty, 1);

        do_op(PUSH, 16'h66);
        chk("wrap1_count", count, 1);
        chk("wrap1_tos",   tos, 16'h66);
        chk("wrap1_nos",   nos, 0);

        do_op(PUSH, 16'h77);
        chk("wrap2_nos", nos, 16'h66);

        do_op(CLEAR, 16'd0);
        chk("clr2_count", count, 0);
`endif

        do_op(PUSH, 16'd2);
        chk("prerst_count", count, 1);
        chk("prerst_tos",   tos, 2);
        reset = 1'b1;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_empty", empty, 1);
        chk("async_rst_tos",   tos, 0);
        @(negedge clk);
        reset = 1'b0;
        do_op(PUSH, 16'd6);
        chk("postrst_count", count, 1);
        chk("postrst_tos",   tos, 6);
        chk("postrst_nos",   nos, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
# stack_unit

Parametrised hardware stack for the single-cycle datapath, successor to the fixed stack memory. It owns its own stack pointer and depth counter and executes one stack operation per clock: push, pop, replace, binary-reduce, dup or clear. The top two entries (TOS, NOS) are presented combinationally for ALU operand fetch. Optional overflow and underflow protection suppresses illegal operations and records a sticky error.

## Interface
Parameters:
- WIDTH, 32, data word width in bits
- DEPTH, 16, number of entries; power of two, 2..256
- Derived: AW = log2(DEPTH); CW = AW+1 (count width)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; one clock; async active-high reset is fixed
- op  in  3  operation code, encodings defined in stack_pkg
- wdata  in  WIDTH  data for PUSH, REPLACE and BINOP
- tos  out  WIDTH  entry at count-1; 0 when count==0
- nos  out  WIDTH  entry at count-2; 0 when count<2
- count  out  CW  number of valid entries, 0..DEPTH
- empty  out  1  count==0
- full  out  1  count==DEPTH
- err  out  1  sticky error; guard build only, else tied 0
- err_code  out  2  first error cause: 01 overflow, 10 underflow; 00 when none

## Operation
- Op codes:
  - NOP 000
  - PUSH 001: mem[count]=wdata, count+1
  - POP 010: count-1
  - REPLACE 011: mem[count-1]=wdata
  - BINOP 100: mem[count-2]=wdata, count-1. This replaces TOS and NOS with the ALU result.
  - DUP 101: mem[count]=tos, count+1
  - CLEAR 110: count=0, err and err_code cleared
  - 111 is reserved and behaves as NOP.
- Only one memory write occurs per cycle. The write address is always count-derived, truncated to AW bits.
- Requirements per op:
  - PUSH: count<DEPTH
  - POP: count>=1
  - REPLACE: count>=1
  - BINOP: count>=2
  - DUP: 1<=count<DEPTH
- Violations are classified as follows:
  - Overflow: PUSH or DUP when full.
  - Underflow: every other violation, including DUP when empty.
- Reset sets count=0, err=0 and err_code=00. Memory contents are not reset. tos and nos therefore read 0 after reset through the count masking.
- Outputs after reset: tos=0, nos=0, count=0, empty=1, full=0, err=0, err_code=00.

## Timing
- op and wdata are sampled on the rising edge of clk. The memory and count update on that same edge.
- tos, nos, count, empty and full are combinational from the registered state. They reflect the new state in the cycle after the op, with zero extra latency. No bypass from wdata is needed.
- err and err_code update on the edge of the offending op.
- err_code holds the first cause until reset or CLEAR. A later error does not overwrite it.
- CLEAR takes priority within its cycle. Reset asserted mid-sequence takes effect immediately and asynchronously. The next op after reset is released executes from count=0.
- PUSH at count=DEPTH-1 sets full=1 in the next cycle. POP at count=1 sets empty=1 in the next cycle.

## Configuration
- STACK_GUARD_EN defined:
  - Illegal ops are suppressed: no memory write and no count change.
  - err is set and err_code is captured as described in Operation.
- STACK_GUARD_EN undefined:
  - Illegal ops are never suppressed. Ops execute unchecked.
  - count wraps modulo 2^CW, and the write address wraps modulo DEPTH.
  - err and err_code are tied to 0.
  - tos and nos still use the count masking rules above.

## Structure
- stack_pkg holds the following:
  - Op-code localparams or typedef: NOP, PUSH, POP, REPLACE, BINOP, DUP, CLEAR.
  - err_code constants ERR_NONE, ERR_OVF, ERR_UNF.
- Sub-module stack_ram: DEPTH x WIDTH, with one synchronous write port and two asynchronous read ports (addresses count-1 and count-2). It contains no reset.
- stack_unit contains the count register, op decode, the legality check under STACK_GUARD_EN, and the tos/nos masking.

## Test plan
- Reset, then PUSH 7, PUSH 4, PUSH 3 → count=3, tos=3, nos=4. Then BINOP wdata=12 → count=2, tos=12, nos=7.
- DUP with tos=12 → count=3, tos=12, nos=12. Then REPLACE 5 → tos=5, nos=12, count=3.
- DEPTH=4: four PUSHes → full=1. A fifth PUSH 9 with the guard → count=4, tos unchanged, err=1, err_code=01. A later POP ×5 leaves err_code=01.
- Guard build, from empty: POP → err=1, err_code=10, count=0, tos=0. BINOP at count=1 → suppressed, count=1.
- CLEAR after an error → count=0, empty=1, err=0, err_code=00. Assert reset between two PUSHes → count=0 immediately, and the next PUSH 6 gives count=1, tos=6.
- Without STACK_GUARD_EN, DEPTH=4: POP from empty → count=31 mod 2^3=7, err=0. Check that wrap and masking behave as documented.
